// File: rtl/ysyx_220066_wb_arbiter_if.sv
// ysyx_220066_wb_arbiter_if: request/ready channels of the three writers plus the registered register-file write port
interface ysyx_220066_wb_arbiter_if #(parameter int XLEN = 64);
  logic            p_valid;
  logic [4:0]      p_rd;
  logic [XLEN-1:0] p_data;
  logic            p_ready;
  logic            mul_valid;
  logic [4:0]      mul_rd;
  logic [XLEN-1:0] mul_data;
  logic            mul_ready;
  logic            div_valid;
  logic [4:0]      div_rd;
  logic [XLEN-1:0] div_data;
  logic            div_ready;
  logic            wb_wen;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            mul_starved;
  logic            div_starved;
  modport master (
    output p_valid, p_rd, p_data, mul_valid, mul_rd, mul_data, div_valid, div_rd, div_data,
    input  p_ready, mul_ready, div_ready, wb_wen, wb_rd, wb_data, mul_starved, div_starved
  );
  modport slave (
    input  p_valid, p_rd, p_data, mul_valid, mul_rd, mul_data, div_valid, div_rd, div_data,
    output p_ready, mul_ready, div_ready, wb_wen, wb_rd, wb_data, mul_starved, div_starved
  );
endinterface

// File: rtl/ysyx_220066_wb_arbiter.sv
// ysyx_220066_wb_arbiter: one-write-per-cycle register-file port shared by pipeline, multiplier and divider
module ysyx_220066_wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_220066_wb_arbiter_if.slave   bus
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [3:0]      mul_wait, div_wait;
  logic            rr;
  logic            p_real, mul_real, div_real;
  logic            mul_st, div_st, any_st;
  logic            g_p, g_mul, g_div, grant;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;
  always_comb begin
    p_real   = bus.p_valid && |bus.p_rd;
    mul_real = bus.mul_valid && |bus.mul_rd;
    div_real = bus.div_valid && |bus.div_rd;
    mul_st   = mul_real && mul_wait == LIM;
    div_st   = div_real && div_wait == LIM;
    any_st   = mul_st || div_st;
    // starved units outrank the pipeline; rr breaks every mul/div tie
    g_mul    = any_st ? mul_st && (!div_st || !rr) : !p_real && mul_real && (!div_real || !rr);
    g_div    = any_st ? div_st && (!mul_st || rr) : !p_real && div_real && (!mul_real || rr);
    g_p      = !any_st && p_real;
    grant    = g_p || g_mul || g_div;
    win_rd   = g_p ? bus.p_rd : g_mul ? bus.mul_rd : bus.div_rd;
    win_data = g_p ? bus.p_data : g_mul ? bus.mul_data : bus.div_data;
  end
  assign bus.p_ready     = rst && bus.p_valid && (!(|bus.p_rd) || g_p);
  assign bus.mul_ready   = rst && bus.mul_valid && (!(|bus.mul_rd) || g_mul);
  assign bus.div_ready   = rst && bus.div_valid && (!(|bus.div_rd) || g_div);
  assign bus.mul_starved = mul_wait == LIM;
  assign bus.div_starved = div_wait == LIM;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr          <= 1'b0;
      mul_wait    <= '0;
      div_wait    <= '0;
      bus.wb_wen  <= 1'b0;
      bus.wb_rd   <= '0;
      bus.wb_data <= '0;
    end else begin
      rr          <= g_mul ? 1'b1 : g_div ? 1'b0 : rr;
      mul_wait    <= (mul_real && !g_mul) ? (mul_wait == LIM ? LIM : mul_wait + 4'd1) : 4'd0;
      div_wait    <= (div_real && !g_div) ? (div_wait == LIM ? LIM : div_wait + 4'd1) : 4'd0;
      bus.wb_wen  <= grant;
      bus.wb_rd   <= grant ? win_rd : bus.wb_rd;
      bus.wb_data <= grant ? win_data : bus.wb_data;
    end
  end
endmodule

// File: tb/tb_ysyx_220066_wb_arbiter.sv
// tb_ysyx_220066_wb_arbiter: directed scenarios plus random traffic against a score-based priority model
module tb_ysyx_220066_wb_arbiter;
  localparam int L = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errs = 0;
  int   checks = 0;
  int   m_rr, m_mw, m_dw;
  logic m_wen;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  always #5 clk = ~clk;
  ysyx_220066_wb_arbiter_if #(.XLEN(64)) bus ();
  ysyx_220066_wb_arbiter #(.XLEN(64), .STARVE_LIMIT(L)) dut (.clk(clk), .rst(rst), .bus(bus));

  // 0 none, 1 pipe, 2 mul, 3 div: highest score wins, equal mul/div scores go to rr
  function automatic int winner();
    int sp, sm, sd;
    sp = (bus.p_valid && bus.p_rd != 0) ? 2 : 0;
    sm = (bus.mul_valid && bus.mul_rd != 0) ? (m_mw >= L ? 3 : 1) : 0;
    sd = (bus.div_valid && bus.div_rd != 0) ? (m_dw >= L ? 3 : 1) : 0;
    if (sp == 0 && sm == 0 && sd == 0) return 0;
    if (sp > sm && sp > sd) return 1;
    if (sm > sd) return 2;
    if (sd > sm) return 3;
    return m_rr == 0 ? 2 : 3;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_mw = 0; m_dw = 0; m_wen = 1'b0; m_rd = '0; m_data = '0;
  endtask

  task automatic idle();
    bus.p_valid = 1'b0; bus.mul_valid = 1'b0; bus.div_valid = 1'b0;
  endtask

  task automatic tick();
    int w;
    w = winner();
    @(posedge clk);
    m_mw = (bus.mul_valid && bus.mul_rd != 0 && w != 2) ? (m_mw < L ? m_mw + 1 : L) : 0;
    m_dw = (bus.div_valid && bus.div_rd != 0 && w != 3) ? (m_dw < L ? m_dw + 1 : L) : 0;
    if (w == 2) m_rr = 1;
    else if (w == 3) m_rr = 0;
    m_wen = w != 0;
    if (w == 1) begin m_rd = bus.p_rd; m_data = bus.p_data; end
    if (w == 2) begin m_rd = bus.mul_rd; m_data = bus.mul_data; end
    if (w == 3) begin m_rd = bus.div_rd; m_data = bus.div_data; end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    bus.p_rd = 5'd5; bus.p_data = 64'h55; bus.mul_rd = '0; bus.mul_data = '0; bus.div_rd = '0; bus.div_data = '0;
    model_reset();
    @(posedge clk);
    #1;
    checks++; if ({bus.wb_wen, bus.wb_rd, bus.wb_data} !== '0) begin errs++; $display("FAIL reset_init wen=%b rd=%0d data=%h exp all 0", bus.wb_wen, bus.wb_rd, bus.wb_data); end
    bus.p_valid = 1'b1;
    #1;
    checks++; if (bus.p_ready !== 1'b0) begin errs++; $display("FAIL reset_ready_forced got=%b exp=0", bus.p_ready); end
    @(negedge clk) rst = 1'b1;
    #1;
    checks++; if (bus.p_ready !== 1'b1) begin errs++; $display("FAIL reset_release_ready got=%b exp=1", bus.p_ready); end
    tick();
    checks++; if (bus.wb_wen !== 1'b1 || bus.wb_rd !== 5'd5) begin errs++; $display("FAIL reset_first_grant wen=%b rd=%0d exp 1/5", bus.wb_wen, bus.wb_rd); end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++; if ({bus.wb_wen, bus.wb_rd, bus.wb_data} !== '0) begin errs++; $display("FAIL reset_async wen=%b rd=%0d data=%h exp all 0", bus.wb_wen, bus.wb_rd, bus.wb_data); end
    checks++; if ({bus.p_ready, bus.mul_ready, bus.div_ready} !== 3'b000) begin errs++; $display("FAIL reset_async_ready got=%b exp=000", {bus.p_ready, bus.mul_ready, bus.div_ready}); end
    @(negedge clk) rst = 1'b1;
    #1;
    checks++; if (bus.p_ready !== 1'b1) begin errs++; $display("FAIL reset_represent_ready got=%b exp=1", bus.p_ready); end
    tick();
    checks++; if (bus.wb_wen !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 64'h55) begin errs++; $display("FAIL reset_represent_wb wen=%b rd=%0d data=%h exp 1/5/55", bus.wb_wen, bus.wb_rd, bus.wb_data); end
    idle();
  endtask

  task automatic test_single_pipe();
    bus.p_valid = 1'b1; bus.p_rd = 5'd3; bus.p_data = 64'hDEAD;
    @(negedge clk);
    checks++; if (bus.p_ready !== 1'b1) begin errs++; $display("FAIL single_ready got=%b exp=1", bus.p_ready); end
    tick();
    idle();
    checks++; if (bus.wb_wen !== 1'b1 || bus.wb_rd !== 5'd3 || bus.wb_data !== 64'hDEAD) begin errs++; $display("FAIL single_wb wen=%b rd=%0d data=%h exp 1/3/dead", bus.wb_wen, bus.wb_rd, bus.wb_data); end
    tick();
    checks++; if (bus.wb_wen !== 1'b0 || bus.wb_rd !== 5'd3) begin errs++; $display("FAIL single_hold wen=%b rd=%0d exp 0/3", bus.wb_wen, bus.wb_rd); end
  endtask

  task automatic test_contention();
    logic [2:0] exp_r;
    bus.mul_valid = 1'b1; bus.mul_rd = 5'd7; bus.mul_data = 64'h7777;
    bus.div_valid = 1'b1; bus.div_rd = 5'd9; bus.div_data = 64'h9999;
    for (int c = 0; c < 6; c++) begin
      bus.p_valid = 1'b1; bus.p_rd = 5'(c + 1); bus.p_data = 64'(c);
      @(negedge clk);
      exp_r = c < 4 ? 3'b100 : c == 4 ? 3'b010 : 3'b001;
      checks++; if ({bus.p_ready, bus.mul_ready, bus.div_ready} !== exp_r) begin errs++; $display("FAIL contention_ready c=%0d got=%b exp=%b", c, {bus.p_ready, bus.mul_ready, bus.div_ready}, exp_r); end
      if (c == 4) begin
        checks++; if ({bus.mul_starved, bus.div_starved} !== 2'b11) begin errs++; $display("FAIL contention_starved got=%b exp=11", {bus.mul_starved, bus.div_starved}); end
      end
      if (c == 5) begin
        checks++; if (bus.wb_rd !== 5'd7 || bus.wb_data !== 64'h7777) begin errs++; $display("FAIL contention_mul_wb rd=%0d data=%h exp 7/7777", bus.wb_rd, bus.wb_data); end
      end
      tick();
      if (c == 4) bus.mul_valid = 1'b0;
    end
    checks++; if (bus.wb_wen !== 1'b1 || bus.wb_rd !== 5'd9) begin errs++; $display("FAIL contention_div_wb wen=%b rd=%0d exp 1/9", bus.wb_wen, bus.wb_rd); end
    idle();
  endtask

  task automatic test_round_robin();
    bus.mul_valid = 1'b1; bus.mul_rd = 5'd10;
    bus.div_valid = 1'b1; bus.div_rd = 5'd11;
    for (int k = 0; k < 6; k++) begin
      bus.mul_data = 64'(100 + k); bus.div_data = 64'(200 + k);
      @(negedge clk);
      checks++; if ({bus.mul_ready, bus.div_ready} !== (k % 2 == 0 ? 2'b10 : 2'b01)) begin errs++; $display("FAIL rr_ready k=%0d got=%b", k, {bus.mul_ready, bus.div_ready}); end
      checks++; if (dut.rr !== 1'(k % 2)) begin errs++; $display("FAIL rr_pointer k=%0d got=%b exp=%0d", k, dut.rr, k % 2); end
      tick();
      checks++; if (bus.wb_rd !== (k % 2 == 0 ? 5'd10 : 5'd11) || bus.wb_data !== 64'(k % 2 == 0 ? 100 + k : 200 + k)) begin errs++; $display("FAIL rr_wb k=%0d rd=%0d data=%0d", k, bus.wb_rd, bus.wb_data); end
    end
    idle();
  endtask

  task automatic test_zero_rd();
    bus.mul_valid = 1'b1; bus.mul_rd = 5'd0; bus.mul_data = 64'hBAD;
    bus.p_valid = 1'b1; bus.p_rd = 5'd4; bus.p_data = 64'h44;
    @(negedge clk);
    checks++; if ({bus.p_ready, bus.mul_ready} !== 2'b11) begin errs++; $display("FAIL zero_ready got=%b exp=11", {bus.p_ready, bus.mul_ready}); end
    tick();
    idle();
    checks++; if (bus.wb_wen !== 1'b1 || bus.wb_rd !== 5'd4 || bus.wb_data !== 64'h44) begin errs++; $display("FAIL zero_wb wen=%b rd=%0d data=%h exp 1/4/44", bus.wb_wen, bus.wb_rd, bus.wb_data); end
    checks++; if (dut.rr !== 1'b0) begin errs++; $display("FAIL zero_rr got=%b exp=0", dut.rr); end
  endtask

  task automatic test_stall_hold();
    logic [63:0] d;
    d = {$urandom, $urandom};
    bus.div_valid = 1'b1; bus.div_rd = 5'd12; bus.div_data = d;
    bus.p_rd = 5'd6; bus.p_data = 64'h66;
    for (int k = 0; k < 3; k++) begin
      bus.p_valid = k < 2;
      @(negedge clk);
      checks++; if (bus.div_ready !== (k == 2)) begin errs++; $display("FAIL stall_ready k=%0d got=%b exp=%b", k, bus.div_ready, k == 2); end
      tick();
      checks++; if (dut.div_wait !== 4'(k < 2 ? k + 1 : 0)) begin errs++; $display("FAIL stall_wait k=%0d got=%0d exp=%0d", k, dut.div_wait, k < 2 ? k + 1 : 0); end
    end
    idle();
    checks++; if (bus.wb_rd !== 5'd12 || bus.wb_data !== d) begin errs++; $display("FAIL stall_wb rd=%0d data=%h exp 12/%h", bus.wb_rd, bus.wb_data, d); end
  endtask

  task automatic test_random();
    bit acc_p, acc_m, acc_d;
    int w;
    do_reset();
    acc_p = 1; acc_m = 1; acc_d = 1;
    for (int n = 0; n < 500; n++) begin
      if (acc_p) begin bus.p_valid = $urandom_range(0, 9) < 6; bus.p_rd = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom); bus.p_data = {$urandom, $urandom}; end
      if (acc_m) begin bus.mul_valid = $urandom_range(0, 1) == 1; bus.mul_rd = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom); bus.mul_data = {$urandom, $urandom}; end
      if (acc_d) begin bus.div_valid = $urandom_range(0, 1) == 1; bus.div_rd = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom); bus.div_data = {$urandom, $urandom}; end
      @(negedge clk);
      w = winner();
      acc_p = !bus.p_valid || bus.p_rd == 0 || w == 1;
      acc_m = !bus.mul_valid || bus.mul_rd == 0 || w == 2;
      acc_d = !bus.div_valid || bus.div_rd == 0 || w == 3;
      checks++; if ({bus.p_ready, bus.mul_ready, bus.div_ready} !== {bus.p_valid && acc_p, bus.mul_valid && acc_m, bus.div_valid && acc_d}) begin errs++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, {bus.p_ready, bus.mul_ready, bus.div_ready}, {bus.p_valid && acc_p, bus.mul_valid && acc_m, bus.div_valid && acc_d}); end
      checks++; if (bus.wb_wen !== m_wen || bus.wb_rd !== m_rd || bus.wb_data !== m_data) begin errs++; $display("FAIL rand_wb n=%0d got=%b/%0d/%h exp=%b/%0d/%h", n, bus.wb_wen, bus.wb_rd, bus.wb_data, m_wen, m_rd, m_data); end
      checks++; if ({bus.mul_starved, bus.div_starved} !== {m_mw >= L, m_dw >= L}) begin errs++; $display("FAIL rand_starved n=%0d got=%b exp=%b", n, {bus.mul_starved, bus.div_starved}, {m_mw >= L, m_dw >= L}); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_pipe();
    test_contention();
    test_round_robin();
    test_zero_rd();
    test_stall_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
